// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared FSM state encoding and paddle command byte values
package uart_sched_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_t;
  localparam logic [7:0] CMD_DOWN = 8'h00;
  localparam logic [7:0] CMD_UP   = 8'h01;
  localparam logic [7:0] CMD_HOLD = 8'h02;
endpackage

// File: rtl/sched_timer.sv
// sched_timer: saturating down-counter reloaded to CYCLES-1, expired when it reaches zero
//  clk, reset : clock, asynchronous active-high reset (reset reloads like load)
//  load       : reload to CYCLES-1
//  en         : decrement by one, sticking at zero
//  expired    : count is zero
module sched_timer #(
  parameter int unsigned CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(CYCLES + 1);
  localparam logic [W-1:0] INIT = W'(CYCLES - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= INIT;
    else if (load) cnt <= INIT;
    else if (en && cnt != '0) cnt <= cnt - W'(1);
  assign expired = cnt == '0;
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one uart_tx between the paddle command and one-shot event bytes
//  cmd_byte           : current paddle command, resent on change or refresh expiry
//  evt_req/evt_byte   : one-cycle event request, held in a one-entry slot
//  tx_active/tx_done  : status from uart_tx
//  tx_dv/tx_byte      : strobe and byte to uart_tx
//  busy, evt_overflow, timeout_err : status; the two error flags are sticky
module uart_tx_sched import uart_sched_pkg::*; #(
  parameter int unsigned GAP_CYCLES     = 1000,
  parameter int unsigned REFRESH_CYCLES = 250000,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] cmd_byte,
  input  logic       evt_req,
  input  logic [7:0] evt_byte,
  input  logic       tx_active,
  input  logic       tx_done,
  output logic       tx_dv,
  output logic [7:0] tx_byte,
  output logic       busy,
  output logic       evt_overflow,
  output logic       timeout_err
);
  state_t state, state_nx;
  logic       evt_pend;
  logic [7:0] evt_q;
  logic [7:0] last_cmd;
  logic [1:0] streak;
  logic refresh_exp, timeout_exp, gap_exp;
  logic cmd_due, evt_avail, grant_cmd, grant_evt, consume, capture;

  assign cmd_due   = (cmd_byte != last_cmd) | refresh_exp;
  // A request arriving in IDLE with the slot empty is granted directly, bypassing the slot.
  assign evt_avail = evt_pend | evt_req;
  // Two back-to-back event grants while the command was due hand the next grant to the command.
  assign grant_cmd = state == ST_IDLE && cmd_due && (!evt_avail || streak == 2'd2);
  assign grant_evt = state == ST_IDLE && evt_avail && !grant_cmd;
  assign consume   = grant_evt && evt_pend;
  assign capture   = evt_req && (consume || (!evt_pend && !grant_evt));

  assign tx_dv = state == ST_LOAD;
  assign busy  = state != ST_IDLE;

  always_comb begin
    state_nx = state;
    state_nx = (state == ST_IDLE) ? ((grant_evt || grant_cmd) ? ST_LOAD : ST_IDLE) :
               (state == ST_LOAD) ? ST_SEND :
               (state == ST_SEND) ? ((tx_done || timeout_exp) ? ST_GAP : ST_SEND) :
                                    ((gap_exp && !tx_active) ? ST_IDLE : ST_GAP);
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_nx;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_byte      <= CMD_HOLD;
      last_cmd     <= CMD_HOLD;
      evt_pend     <= 1'b0;
      evt_q        <= 8'h00;
      streak       <= 2'd0;
      evt_overflow <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      if (grant_evt) tx_byte <= evt_pend ? evt_q : evt_byte;
      if (grant_cmd) tx_byte <= cmd_byte;
      if (grant_cmd) last_cmd <= cmd_byte;
      if (grant_cmd) streak <= 2'd0;
      else if (grant_evt) streak <= cmd_due ? streak + 2'd1 : 2'd0;
      if (capture) evt_q <= evt_byte;
      evt_pend <= capture ? 1'b1 : consume ? 1'b0 : evt_pend;
      if (evt_req && evt_pend && !consume) evt_overflow <= 1'b1;
      if (state == ST_SEND && timeout_exp && !tx_done) timeout_err <= 1'b1;
    end

  sched_timer #(.CYCLES(REFRESH_CYCLES)) u_refresh (
    .clk(clk), .reset(reset), .load(grant_cmd), .en(1'b1), .expired(refresh_exp)
  );
  sched_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .reset(reset), .load(state == ST_LOAD), .en(state == ST_SEND), .expired(timeout_exp)
  );
  sched_timer #(.CYCLES(GAP_CYCLES)) u_gap (
    .clk(clk), .reset(reset), .load(state == ST_SEND), .en(state == ST_GAP), .expired(gap_exp)
  );
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: scoreboard bench for uart_tx_sched with a behavioural uart_tx model
module tb_uart_tx_sched;
  localparam int G = 20;
  localparam int R = 50;
  localparam int T = 100;
  localparam int L = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] cmd_byte = 8'h02;
  logic evt_req = 1'b0;
  logic [7:0] evt_byte = 8'h00;
  logic tx_active = 1'b0;
  logic tx_done = 1'b0;
  logic withhold = 1'b0;
  logic tx_dv, busy, evt_overflow, timeout_err;
  logic [7:0] tx_byte;
  logic prev_dv = 1'b0;
  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(.GAP_CYCLES(G), .REFRESH_CYCLES(R), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .cmd_byte(cmd_byte), .evt_req(evt_req), .evt_byte(evt_byte),
    .tx_active(tx_active), .tx_done(tx_done), .tx_dv(tx_dv), .tx_byte(tx_byte),
    .busy(busy), .evt_overflow(evt_overflow), .timeout_err(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [7:0] b);
    evt_req = 1'b1;
    evt_byte = b;
    @(negedge clk);
    evt_req = 1'b0;
  endtask

  task automatic wait_dv(input string tag, output int k);
    k = 0;
    while (!tx_dv && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_dv_seen"}, tx_dv, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || exp_q.size() != 0) && k < 600);
    chk({tag, "_idle"}, busy || exp_q.size() != 0, 0);
  endtask

  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (reset) begin
        cnt = 0;
        tx_active = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          tx_active = 1'b0;
          tx_done = !withhold;
        end
      end else if (tx_dv) begin
        tx_active = 1'b1;
        cnt = L;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && tx_dv) begin
        chk("dv_one_cycle", prev_dv, 0);
        chk("dv_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("tx_byte", tx_byte, exp_q.pop_front());
      end
      prev_dv = tx_dv;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    tick(3);
    chk("rst_dv", tx_dv, 0);
    chk("rst_byte", tx_byte, 8'h02);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", evt_overflow, 0);
    chk("rst_tout", timeout_err, 0);
    reset = 1'b0;
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h02);
    wait_dv("t1a", k);
    chk("t1_first_latency", k, R);
    tick(1);
    wait_dv("t1b", k);
    chk("t1_period", k + 1, R);
    wait_idle("t1");

    cmd_byte = 8'h01;
    exp_q.push_back(8'h01);
    wait_dv("t2", k);
    chk("t2_latency", k, 1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 200);
    chk("t2_busy_len", k, L + G + 1);
    wait_idle("t2");

    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    cmd_byte = 8'h00;
    pulse(8'hA5);
    wait_idle("t3");

    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h00);
    pulse(8'h11);
    wait_dv("t4", k);
    tick(1);
    pulse(8'h22);
    chk("t4_ovf_clear", evt_overflow, 0);
    pulse(8'h33);
    chk("t4_ovf_set", evt_overflow, 1);
    pulse(8'h44);
    wait_idle("t4");
    chk("t4_ovf_sticky", evt_overflow, 1);

    exp_q.push_back(8'h55);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h77);
    exp_q.push_back(8'h01);
    cmd_byte = 8'h01;
    pulse(8'h55);
    wait_dv("t5a", k);
    tick(1);
    pulse(8'h66);
    wait_dv("t5b", k);
    tick(1);
    pulse(8'h77);
    wait_idle("t5");

    withhold = 1'b1;
    exp_q.push_back(8'h99);
    exp_q.push_back(8'h01);
    pulse(8'h99);
    k = 0;
    while (!timeout_err && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("t6_timeout_at", k, T + 1);
    chk("t6_busy_in_gap", busy, 1);
    withhold = 1'b0;
    wait_idle("t6");
    chk("t6_err_sticky", timeout_err, 1);

    exp_q.push_back(8'h3C);
    pulse(8'h3C);
    tick(1);
    pulse(8'h4D);
    #2 reset = 1'b1;
    #1;
    chk("t7_dv", tx_dv, 0);
    chk("t7_busy", busy, 0);
    chk("t7_byte", tx_byte, 8'h02);
    chk("t7_ovf", evt_overflow, 0);
    chk("t7_tout", timeout_err, 0);
    cmd_byte = 8'h02;
    @(negedge clk);
    reset = 1'b0;
    exp_q.push_back(8'h02);
    wait_dv("t7", k);
    chk("t7_refresh_after_reset", k, R);
    wait_idle("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
